trng_block_packer: RTL and testbench
====================================

// Module: trng_block_packer
// PURPOSE
//   Upstream stage of aespp. Packs raw TRNG bits into 128-bit blocks, runs a
//   repetition-count health test (RCT) on them, and presents finished blocks
//   on aespp's i_dat/i_valid. Double-buffered: one fill register and one hold
//   register, so sampling continues while aespp conditions the current block.
// PARAMETERS
//   RCT_CUTOFF  32  run of identical consecutive accepted bits that fails the RCT (>=2)
//   DROP_W      16  width of the saturating dropped-bit counter
// PORTS
//   i_clk          in   1    single clock, rising edge
//   i_reset        in   1    synchronous, active-high reset
//   i_bit_valid    in   1    i_bit is a fresh raw sample this cycle
//   i_bit          in   1    raw entropy bit
//   i_consumed     in   1    from aespp o_input_consummed; releases the hold block
//   i_clear_fail   in   1    clears o_health_fail and restarts the RCT
//   o_dat          out  128  hold block, to aespp i_dat
//   o_valid        out  1    hold block present, to aespp i_valid
//   o_health_fail  out  1    sticky RCT failure flag
//   o_drop_count   out  DROP_W  bits lost while fill is full; saturates at all-ones
// BEHAVIOUR
// - Reset: o_dat=0, o_valid=0, o_health_fail=0, o_drop_count=0, fill count=0,
//   fill_full=0, RCT run length=0. Reset mid-fill discards the partial block.
// - Accepted bit: i_bit_valid & ~fill_full & ~o_health_fail & ~i_clear_fail.
//   The k-th accepted bit of a block (k=0..127) lands at bit k; o_dat[0] is the first bit.
// - Completion: 128th bit accepted in cycle N:
//   * hold free in N (o_valid=0, or i_consumed=1): o_dat={i_bit,fill[126:0]}
//     and o_valid=1 from N+1; fill count returns to 0.
//   * otherwise fill_full=1 and further bits are dropped.
// - i_consumed with o_valid=1: if fill_full, load hold from fill on the next
//   edge (o_valid stays 1, o_dat changes) and clear fill_full; else o_valid=0.
//   i_consumed with o_valid=0 is ignored. Holding o_valid after aespp samples
//   is harmless: aespp reads i_dat only in its round 0.
// - Drop: i_bit_valid & fill_full & ~o_health_fail -> o_drop_count+1, saturating.
//   Bits arriving while o_health_fail=1 are ignored and not counted.
// - RCT: run length counts identical consecutive accepted bits; the first bit
//   after reset or clear counts as 1, and a bit differing from the last resets
//   it to 1. When an accepted bit makes the run equal RCT_CUTOFF: that bit is
//   not stored, o_health_fail=1 from the next cycle, the partial fill and
//   fill_full are discarded, and the hold block and o_valid are unaffected.
// - i_clear_fail: o_health_fail=0, run length=0, fill count=0. Any bit in the
//   same cycle is ignored (clear wins). o_drop_count is not cleared.
// - Widths: fill count 7 bits with no wrap beyond 127; run counter
//   $clog2(RCT_CUTOFF+1) bits, saturating.
// STRUCTURE
// - trng_pkg: AES_BLOCK_W=128, FILL_CNT_W=7, and the bit-ordering convention
//   shared with aespp.
// - One sub-module, trng_rct (last bit, run counter, fail pulse, clear input).
//   Packing and buffering stay in this module.
// TESTING
// 1 128 bits 0,1,0,1... with hold empty -> o_valid=1 the cycle after the last
//   bit, o_dat=128'hAAAA..AA, no fail.
// 2 256 bits of 0011 repeating, no i_consumed, then 10 more bits -> o_dat=128'hCCCC..CC,
//   o_drop_count=10; pulse i_consumed -> o_valid stays 1, o_dat holds the second block.
// 3 31 ones then a zero -> no fail; then 32 ones -> o_health_fail=1 the next cycle
//   and o_valid unchanged; 50 more bits ignored, drop count unchanged;
//   i_clear_fail then 128 alternating bits -> new block 128'hAAAA..AA.
// 4 60 bits, then i_reset for 1 cycle -> all outputs 0; 128 alternating bits
//   -> block equals 128'hAAAA..AA (no stale bits).
// 5 o_valid=1, and i_consumed arrives in the same cycle as the 128th bit of the
//   next block -> o_valid stays 1 and o_dat is the new block on the next cycle.
// 6 DROP_W=4, fill_full and hold full, 20 bit_valid cycles -> o_drop_count=4'hF.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: block geometry and bit-ordering shared by the TRNG packer and aespp.
// Ports: none (package). Provides AES_BLOCK_W, FILL_CNT_W, LAST_BIT_IDX.
// Ordering: the k-th accepted bit of a block is placed at bit k, so dat[0] is the oldest bit.
package trng_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int FILL_CNT_W  = 7;

  // Index of the final bit of a block. Accepting the bit at this index completes the block.
  localparam logic [FILL_CNT_W-1:0] LAST_BIT_IDX = FILL_CNT_W'(AES_BLOCK_W - 1);

endpackage

// File: rtl/trng_rct.sv
// trng_rct: repetition-count health test on the stream of accepted TRNG bits.
// Ports: clk/reset, strobe+value (accepted bit), clear (restart test),
//        trip (combinational: this bit reaches the cutoff), fail (sticky, registered).
module trng_rct #(
  parameter int RCT_CUTOFF = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic value,
  input  logic clear,
  output logic trip,
  output logic fail
);

  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  logic             last;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;

  // A run of 0 means "no bit seen since reset/clear", so the next bit always starts at 1.
  always_comb begin
    run_next = run;
    if (run == '0 || value != last) begin
      run_next = RUN_W'(1);
    end else if (run != '1) begin
      run_next = run + RUN_W'(1);
    end
  end

  assign trip = strobe & (run_next == RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b0;
      run  <= '0;
      fail <= 1'b0;
    end else if (clear) begin
      run  <= '0;
      fail <= 1'b0;
    end else if (strobe) begin
      last <= value;
      run  <= run_next;
      if (trip) begin
        fail <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_block_packer.sv
// trng_block_packer: packs raw TRNG bits into 128-bit blocks for aespp, double-buffered.
// Ports: i_bit_valid/i_bit raw samples; i_consumed releases hold; i_clear_fail restarts RCT;
//        o_dat/o_valid hold block; o_health_fail sticky RCT flag; o_drop_count saturating drops.
module trng_block_packer
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = 32,
  parameter int DROP_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_bit_valid,
  input  logic                   i_bit,
  input  logic                   i_consumed,
  input  logic                   i_clear_fail,
  output logic [AES_BLOCK_W-1:0] o_dat,
  output logic                   o_valid,
  output logic                   o_health_fail,
  output logic [DROP_W-1:0]      o_drop_count
);

  logic [AES_BLOCK_W-1:0] fill;
  logic [FILL_CNT_W-1:0]  cnt;
  logic                   fill_full;

  logic accept;
  logic trip;
  logic store;
  logic last_bit;
  logic hold_free;
  logic consume;
  logic drop;

  // Clear wins over a same-cycle bit; a failed test blocks everything until cleared.
  assign accept    = i_bit_valid & ~fill_full & ~o_health_fail & ~i_clear_fail;
  // The bit that trips the RCT is never written into the fill register.
  assign store     = accept & ~trip;
  assign last_bit  = store & (cnt == LAST_BIT_IDX);
  assign hold_free = ~o_valid | i_consumed;
  assign consume   = o_valid & i_consumed;
  assign drop      = i_bit_valid & fill_full & ~o_health_fail & ~(&o_drop_count);

  trng_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk   (i_clk),
    .reset (i_reset),
    .strobe(accept),
    .value (i_bit),
    .clear (i_clear_fail),
    .trip  (trip),
    .fail  (o_health_fail)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fill         <= '0;
      cnt          <= '0;
      fill_full    <= 1'b0;
      o_dat        <= '0;
      o_valid      <= 1'b0;
      o_drop_count <= '0;
    end else begin
      // Fill side. Count restarts at every completion, whether the block moved to
      // hold or is parked in fill waiting for hold to free up.
      if (store) begin
        fill[cnt] <= i_bit;
        cnt       <= last_bit ? '0 : cnt + FILL_CNT_W'(1);
      end
      if (trip || i_clear_fail) begin
        cnt <= '0;
      end

      if (trip) begin
        fill_full <= 1'b0;
      end else if (last_bit && !hold_free) begin
        fill_full <= 1'b1;
      end else if (consume && fill_full) begin
        fill_full <= 1'b0;
      end

      // Hold side. The completing bit bypasses the fill register so the block is
      // visible the cycle after its last bit.
      if (last_bit && hold_free) begin
        o_dat   <= {i_bit, fill[AES_BLOCK_W-2:0]};
        o_valid <= 1'b1;
      end else if (consume && fill_full) begin
        o_dat <= fill;
      end else if (consume) begin
        o_valid <= 1'b0;
      end

      if (drop) begin
        o_drop_count <= o_drop_count + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trng_block_packer.sv
// tb_trng_block_packer: directed self-checking bench for trng_block_packer.
// Ports: none. Two instances share stimulus: default widths and DROP_W=4.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_trng_block_packer;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_bit_valid;
  logic         i_bit;
  logic         i_consumed;
  logic         i_clear_fail;
  logic [127:0] o_dat;
  logic         o_valid;
  logic         o_health_fail;
  logic [15:0]  o_drop_count;
  logic [127:0] dat4;
  logic         valid4;
  logic         fail4;
  logic [3:0]   drop4;

  int vectors;
  int miscompares;

  localparam logic [127:0] BLK_A = {32{4'hA}};
  localparam logic [127:0] BLK_C = {32{4'hC}};

  always #5 i_clk = ~i_clk;

  trng_block_packer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_consumed(i_consumed), .i_clear_fail(i_clear_fail), .o_dat(o_dat),
    .o_valid(o_valid), .o_health_fail(o_health_fail), .o_drop_count(o_drop_count)
  );

  trng_block_packer #(.DROP_W(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
    .i_consumed(i_consumed), .i_clear_fail(i_clear_fail), .o_dat(dat4),
    .o_valid(valid4), .o_health_fail(fail4), .o_drop_count(drop4)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic cons);
    i_bit_valid = 1'b1;
    i_bit       = b;
    i_consumed  = cons;
    tick();
    i_bit_valid = 1'b0;
    i_consumed  = 1'b0;
  endtask

  // pat 0: 0,1,0,1...   pat 1: 0,0,1,1,...
  task automatic send_pattern(input int n, input int pat);
    for (int k = 0; k < n; k++) begin
      send_bit(pat == 0 ? k[0] : k[1], 1'b0);
    end
  endtask

  task automatic pulse_consume();
    i_consumed = 1'b1;
    tick();
    i_consumed = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    vectors++; if (o_dat !== 128'd0) begin miscompares++; $display("FAIL reset_dat got %h want 0", o_dat); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_valid); end
    vectors++; if (o_health_fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail got %b want 0", o_health_fail); end
    vectors++; if (o_drop_count !== 16'd0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", o_drop_count); end
    vectors++; if (drop4 !== 4'd0) begin miscompares++; $display("FAIL reset_drop4 got %0d want 0", drop4); end
  endtask

  task automatic test_alternating();
    send_pattern(127, 0);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL alt_early_valid got %b want 0", o_valid); end
    send_bit(1'b1, 1'b0);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL alt_valid got %b want 1", o_valid); end
    vectors++; if (o_dat !== BLK_A) begin miscompares++; $display("FAIL alt_dat got %h want %h", o_dat, BLK_A); end
    vectors++; if (o_health_fail !== 1'b0) begin miscompares++; $display("FAIL alt_fail got %b want 0", o_health_fail); end
    pulse_consume();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL alt_release got %b want 0", o_valid); end
  endtask

  task automatic test_double_buffer();
    send_pattern(256, 1);
    send_pattern(10, 0);
    vectors++; if (o_dat !== BLK_C) begin miscompares++; $display("FAIL dbuf_dat got %h want %h", o_dat, BLK_C); end
    vectors++; if (o_drop_count !== 16'd10) begin miscompares++; $display("FAIL dbuf_drop got %0d want 10", o_drop_count); end
    pulse_consume();
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL dbuf_swap_valid got %b want 1", o_valid); end
    vectors++; if (o_dat !== BLK_C) begin miscompares++; $display("FAIL dbuf_swap_dat got %h want %h", o_dat, BLK_C); end
    // Fill is empty again, so a new bit is accepted, not dropped.
    send_bit(1'b0, 1'b0);
    vectors++; if (o_drop_count !== 16'd10) begin miscompares++; $display("FAIL dbuf_accept got %0d want 10", o_drop_count); end
  endtask

  task automatic test_rct();
    // Restart the RCT; the bit sent during clear must be ignored.
    i_clear_fail = 1'b1; i_bit_valid = 1'b1; i_bit = 1'b1;
    tick();
    i_clear_fail = 1'b0; i_bit_valid = 1'b0;
    for (int k = 0; k < 31; k++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    vectors++; if (o_health_fail !== 1'b0) begin miscompares++; $display("FAIL rct_31_fail got %b want 0", o_health_fail); end
    for (int k = 0; k < 31; k++) send_bit(1'b1, 1'b0);
    vectors++; if (o_health_fail !== 1'b0) begin miscompares++; $display("FAIL rct_pre_fail got %b want 0", o_health_fail); end
    send_bit(1'b1, 1'b0);
    vectors++; if (o_health_fail !== 1'b1) begin miscompares++; $display("FAIL rct_trip got %b want 1", o_health_fail); end
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL rct_hold_valid got %b want 1", o_valid); end
    vectors++; if (o_dat !== BLK_C) begin miscompares++; $display("FAIL rct_hold_dat got %h want %h", o_dat, BLK_C); end
    send_pattern(50, 0);
    vectors++; if (o_drop_count !== 16'd10) begin miscompares++; $display("FAIL rct_drop got %0d want 10", o_drop_count); end
    vectors++; if (o_health_fail !== 1'b1) begin miscompares++; $display("FAIL rct_sticky got %b want 1", o_health_fail); end
    i_clear_fail = 1'b1; i_bit_valid = 1'b1; i_bit = 1'b1;
    tick();
    i_clear_fail = 1'b0; i_bit_valid = 1'b0;
    vectors++; if (o_health_fail !== 1'b0) begin miscompares++; $display("FAIL rct_clear got %b want 0", o_health_fail); end
    pulse_consume();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rct_release got %b want 0", o_valid); end
    send_pattern(128, 0);
    vectors++; if (o_valid !== 1'b1 || o_dat !== BLK_A) begin miscompares++; $display("FAIL rct_newblk got %b/%h want 1/%h", o_valid, o_dat, BLK_A); end
  endtask

  task automatic test_mid_reset();
    send_pattern(60, 1);
    do_reset();
    vectors++; if (o_valid !== 1'b0 || o_dat !== 128'd0) begin miscompares++; $display("FAIL mrst_out got %b/%h want 0/0", o_valid, o_dat); end
    vectors++; if (o_drop_count !== 16'd0 || o_health_fail !== 1'b0) begin miscompares++; $display("FAIL mrst_flags got %0d/%b want 0/0", o_drop_count, o_health_fail); end
    send_pattern(127, 0);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_early got %b want 0", o_valid); end
    send_bit(1'b1, 1'b0);
    vectors++; if (o_dat !== BLK_A) begin miscompares++; $display("FAIL mrst_blk got %h want %h", o_dat, BLK_A); end
  endtask

  task automatic test_back_to_back();
    // Hold has BLK_A; next block completes on the same edge as the consume.
    for (int k = 0; k < 127; k++) send_bit(k[1], 1'b0);
    vectors++; if (o_dat !== BLK_A) begin miscompares++; $display("FAIL b2b_pre got %h want %h", o_dat, BLK_A); end
    send_bit(1'b1, 1'b1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", o_valid); end
    vectors++; if (o_dat !== BLK_C) begin miscompares++; $display("FAIL b2b_dat got %h want %h", o_dat, BLK_C); end
    pulse_consume();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_release got %b want 0", o_valid); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    send_pattern(256, 0);
    send_pattern(20, 0);
    vectors++; if (drop4 !== 4'hF) begin miscompares++; $display("FAIL sat_drop4 got %h want f", drop4); end
    vectors++; if (o_drop_count !== 16'd20) begin miscompares++; $display("FAIL sat_drop16 got %0d want 20", o_drop_count); end
    vectors++; if (valid4 !== 1'b1 || dat4 !== BLK_A || fail4 !== 1'b0) begin miscompares++; $display("FAIL sat_hold4 got %b/%h/%b want 1/%h/0", valid4, dat4, fail4, BLK_A); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    i_reset      = 1'b1;
    i_bit_valid  = 1'b0;
    i_bit        = 1'b0;
    i_consumed   = 1'b0;
    i_clear_fail = 1'b0;
    tick();
    test_reset();
    test_alternating();
    test_double_buffer();
    test_rct();
    test_mid_reset();
    test_back_to_back();
    test_drop_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
